// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES job arbiter: block width, core mode and arbiter FSM states.
package aes_ctrl_pkg;

   localparam int unsigned AES_BLK_W = 128;

   typedef enum logic {
      ENC = 1'b0,
      DEC = 1'b1
   } aes_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      RESP
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set valid bit at or above ptr (with wrap),
// returned both one-hot and as an index.
module rr_arbiter
   import aes_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IdW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IdW-1:0]     ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IdW-1:0]     gnt_idx,
   output logic               any
);

   logic [IdW:0]   sum;
   logic [IdW-1:0] cand;
   logic           found;

   always_comb begin
      gnt   = '0;
      sum   = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         // ptr + i, folded back into 0..NUM_REQ-1
         sum = {1'b0, ptr} + (IdW+1)'(i);
         if (sum >= (IdW+1)'(NUM_REQ)) begin
            sum = sum - (IdW+1)'(NUM_REQ);
         end
         cand = sum[IdW-1:0];
         if (!found && valid[cand]) begin
            gnt[cand] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            gnt_idx = IdW'(i);
         end
      end
   end

   assign any = |valid;

endmodule

// File: rtl/aes_job_arbiter.sv
// Round-robin job arbiter sharing one AES encrypt/decrypt core pair between NUM_REQ requesters.
// Optional engine watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_job_arbiter
   import aes_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_mode,
   input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key,
   input  logic [NUM_REQ*AES_BLK_W-1:0]   req_data,
   output logic                           enc_start,
   output logic                           dec_start,
   output logic [AES_BLK_W-1:0]           eng_key,
   output logic [AES_BLK_W-1:0]           eng_data,
   input  logic                           enc_done,
   input  logic                           dec_done,
   input  logic [AES_BLK_W-1:0]           enc_result,
   input  logic [AES_BLK_W-1:0]           dec_result,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
   output logic [AES_BLK_W-1:0]           rsp_data,
   output logic                           rsp_err
);

   localparam int unsigned IdW = $clog2(NUM_REQ);

   arb_state_e           state_q, state_d;
   logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]       id_q, id_d;
   aes_mode_e            mode_q, mode_d;
   logic [AES_BLK_W-1:0] key_q, key_d;
   logic [AES_BLK_W-1:0] data_q, data_d;
   logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;

   logic [NUM_REQ-1:0]   gnt;
   logic [IdW-1:0]       gnt_idx;
   logic                 gnt_any;
   logic                 sel_done;

   logic [AES_BLK_W-1:0] key_arr  [NUM_REQ];
   logic [AES_BLK_W-1:0] data_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign key_arr[i]  = req_key[i*AES_BLK_W +: AES_BLK_W];
      assign data_arr[i] = req_data[i*AES_BLK_W +: AES_BLK_W];
   end

`ifdef AES_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IdW     (IdW)
   ) u_rr (
      .valid   (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   // Only the core matching the latched job may complete it.
   assign sel_done = (mode_q == DEC) ? dec_done : enc_done;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      id_d       = id_q;
      mode_d     = mode_q;
      key_d      = key_q;
      data_d     = data_q;
      rsp_data_d = rsp_data_q;
      req_ready  = '0;
      enc_start  = 1'b0;
      dec_start  = 1'b0;
      rsp_valid  = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (gnt_any && !rst) begin
               req_ready = gnt;
               id_d      = gnt_idx;
               mode_d    = aes_mode_e'(req_mode[gnt_idx]);
               key_d     = key_arr[gnt_idx];
               data_d    = data_arr[gnt_idx];
               rr_ptr_d  = (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdW'(1);
               state_d   = LAUNCH;
            end
         end
         LAUNCH: begin
            enc_start = (mode_q == ENC);
            dec_start = (mode_q == DEC);
            state_d   = WAIT;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         WAIT: begin
            if (sel_done) begin
               rsp_data_d = (mode_q == DEC) ? dec_result : enc_result;
               state_d    = RESP;
`ifdef AES_ARB_TIMEOUT_EN
               err_d      = 1'b0;
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               rsp_data_d = '0;
               err_d      = 1'b1;
               state_d    = RESP;
            end else begin
               cnt_d      = cnt_q + CntW'(1);
`endif
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         id_q       <= '0;
         mode_q     <= ENC;
         key_q      <= '0;
         data_q     <= '0;
         rsp_data_q <= '0;
`ifdef AES_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         id_q       <= id_d;
         mode_q     <= mode_d;
         key_q      <= key_d;
         data_q     <= data_d;
         rsp_data_q <= rsp_data_d;
`ifdef AES_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign eng_key  = key_q;
   assign eng_data = data_q;
   assign rsp_id   = id_q;
   assign rsp_data = rsp_data_q;
`ifdef AES_ARB_TIMEOUT_EN
   assign rsp_err  = err_q;
`else
   assign rsp_err  = 1'b0;
`endif

endmodule

// File: doc/aes_job_arbiter.md
# aes_job_arbiter

Shares one AES engine pair (128-bit encrypt core and decrypt core, start/done handshake) between `NUM_REQ` requesters. Grants jobs round-robin, launches the selected core, waits for its done, and returns the result tagged with the requester index. Sits between the host-side job queues and the Encrypt/Decrypt top-levels in the accelerator.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 64, engine watchdog limit; used only with `AES_ARB_TIMEOUT_EN`
- `clk`  in  1  clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  job offered by requester i
- `req_ready`  out  NUM_REQ  job accepted from requester i this cycle
- `req_mode`  in  NUM_REQ  per requester: 0 = encrypt, 1 = decrypt
- `req_key`  in  NUM_REQ*128  per-requester key, slice i = bits [128i+127:128i]
- `req_data`  in  NUM_REQ*128  per-requester plaintext/ciphertext
- `enc_start`, `dec_start`  out  1  one-cycle launch pulse to the selected core
- `eng_key`, `eng_data`  out  128  operands to both cores, stable from launch until done
- `enc_done`, `dec_done`  in  1  core completion (level or pulse)
- `enc_result`, `dec_result`  in  128  core outputs, valid while done is high
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  $clog2(NUM_REQ)  index of the originating requester
- `rsp_data`  out  128  result block
- `rsp_err`  out  1  job aborted by watchdog

## Operation
- FSM: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE: round-robin grant among set `req_valid` bits, searching from `rr_ptr` upward with wrap. `req_ready[g]` is high combinationally only for grant g. On handshake, latch mode, key, data, and id. Set `rr_ptr` = g+1 mod NUM_REQ. Go to LAUNCH. With no valid request, stay in IDLE.
- LAUNCH: pulse `enc_start` or `dec_start` for exactly one cycle, according to the latched mode. Go to WAIT.
- WAIT: watch only the selected core's done. On the first cycle it is high, capture that core's result into `rsp_data` and go to RESP. The other core's done and any done outside WAIT are ignored.
- RESP: `rsp_valid` = 1. Data, id, and err are held stable until `rsp_ready`. On handshake, go to IDLE. No new grant is made while a response is pending.
- Reset, including mid-job: state = IDLE, `rr_ptr` = 0, every output 0, latched operands cleared. The engine is not otherwise signalled.
- Mode bit is a 1-bit enum. `rsp_id` is zero-extended to its width.

## Timing
- Reset values: `req_ready` = 0, `enc_start` = `dec_start` = 0, `eng_key` = `eng_data` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_err` = 0.
- Accept in cycle T. Start pulse in T+1. Done seen at T+1+N. `rsp_valid` rises at T+2+N.
- Minimum job-to-job spacing is 4 cycles plus engine latency. Back-to-back fairness: two always-valid requesters alternate 0,1,0,1.
- `eng_key`/`eng_data` update only on accept.

## Configuration
- `AES_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT. After `TIMEOUT_CYCLES` cycles without done, go to RESP with `rsp_err` = 1 and `rsp_data` = 0.
  - If done and expiry occur in the same cycle, done wins and `rsp_err` = 0.
- Not defined: no counter, `rsp_err` tied 0, and WAIT holds indefinitely.

## Structure
- Package `aes_ctrl_pkg`:
  - `AES_BLK_W` = 128
  - `aes_mode_e` (ENC = 0, DEC = 1)
  - `arb_state_e` (IDLE, LAUNCH, WAIT, RESP)
- Sub-module `rr_arbiter`: parameterized, combinational grant from the valid vector and pointer, plus one-hot-to-index. It is instantiated once.

## Test plan
- Single decrypt, requester 0: ct 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f -> `rsp_data` 00112233445566778899aabbccddeeff, `rsp_id` 0, `rsp_err` 0.
- Single encrypt, requester 1: pt 6bc1bee22e409f96e93d7e117393172a, key 2b7e151628aed2a6abf7158809cf4f3c -> `rsp_data` 3ad77bb40d7a3660a89ecaf32466ef97, `rsp_id` 1.
- Both requesters continuously valid for 6 jobs -> grant order 0,1,0,1,0,1. Each start is a single-cycle pulse to the core matching the job's mode.
- Response back-pressure: hold `rsp_ready` = 0 for 10 cycles -> `rsp_valid`/`rsp_data` stable, and `req_ready` stays 0 throughout.
- `rst` asserted during WAIT -> next cycle all outputs 0. A later done pulse is ignored, and the next job is granted to requester 0.
- With `AES_ARB_TIMEOUT_EN`, engine model never asserts done -> `rsp_valid` at exactly T+2+64 with `rsp_err` 1 and `rsp_data` 0. Done coincident with expiry -> `rsp_err` 0.
